// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Purpose: sequential instruction fetcher. It issues word-aligned fetch
// requests to instruction memory, keeps at most two requests in flight or
// buffered, collects in-order responses in a 2-entry {word, pc} FIFO and
// presents the FIFO head to decode. A redirect flushes the FIFO, restarts
// fetching at the (word-aligned) target and discards responses that belong
// to requests issued before the redirect.
//
// Parameters:
//   RESET_PC        first fetch address after reset
//
// Ports:
//   clk             clock, all state on rising edge
//   reset           synchronous active-high reset
//   imem_req_valid  fetch request valid
//   imem_req_addr   fetch word address (bits [1:0] always 00)
//   imem_req_ready  memory accepts the request
//   imem_rsp_valid  instruction word returning (in request order)
//   imem_rsp_data   returned instruction word
//   redirect_valid  taken branch/jump pulse
//   redirect_pc     redirect target
//   instr_valid     instruction available to decode
//   instr_ready     decode consumes the instruction
//   instr           instruction word at FIFO head
//   instr_pc        address of instr
//   instr_op        instr[6:0] for the main decoder
//   misalign_err    (FETCH_MISALIGN_CHECK_EN only) sticky misaligned-redirect flag
//
// Build option:
//   FETCH_MISALIGN_CHECK_EN  adds misalign_err; without it a misaligned
//                            redirect target is silently word-aligned.
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [6:0]  instr_op
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic        misalign_err
`endif
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t      state_r;
    logic [31:0] fetch_pc_r;
    logic [31:0] rsp_pc_r;
    logic [1:0]  out_cnt_r;     // requests accepted, response not yet seen
    logic [1:0]  drop_cnt_r;    // of those, how many belong to a stale stream
    logic [31:0] fifo_word_r [2];
    logic [31:0] fifo_pc_r   [2];
    logic        rd_ptr_r;
    logic        wr_ptr_r;
    logic [1:0]  fifo_cnt_r;

    logic        credit_s;
    logic        accept_s;
    logic        rsp_s;
    logic        keep_s;
    logic        pop_s;
    logic [31:0] redirect_tgt_s;
    logic [1:0]  out_cnt_nxt_s;
    logic [1:0]  drop_cnt_nxt_s;
    logic [1:0]  fifo_cnt_nxt_s;

    // In-flight plus buffered never exceeds two, so every kept response has a FIFO slot.
    assign credit_s = (({1'b0, out_cnt_r} + {1'b0, fifo_cnt_r}) < 3'd2);

    assign imem_req_valid = !reset && (state_r != ST_BOOT) && !redirect_valid && credit_s;
    assign imem_req_addr  = fetch_pc_r;
    assign accept_s       = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding cannot be ours; ignore it.
    assign rsp_s  = imem_rsp_valid && (out_cnt_r != 2'd0);
    assign keep_s = rsp_s && !redirect_valid && (drop_cnt_r == 2'd0);

    assign instr_valid = !reset && (fifo_cnt_r != 2'd0);
    assign pop_s       = instr_valid && instr_ready;
    assign instr       = fifo_word_r[rd_ptr_r];
    assign instr_pc    = fifo_pc_r[rd_ptr_r];
    assign instr_op    = instr[6:0];

    // Low target bits are always dropped; misalignment is only reported, never honoured.
    assign redirect_tgt_s = redirect_pc & 32'hFFFF_FFFC;

    // Next-value computation for the in-flight, drop and FIFO occupancy counters.
    always_comb begin
        out_cnt_nxt_s  = out_cnt_r;
        drop_cnt_nxt_s = drop_cnt_r;
        fifo_cnt_nxt_s = fifo_cnt_r;

        case ({accept_s, rsp_s})
            2'b10:   out_cnt_nxt_s = out_cnt_r + 2'd1;
            2'b01:   out_cnt_nxt_s = out_cnt_r - 2'd1;
            default: out_cnt_nxt_s = out_cnt_r;
        endcase

        // Everything still in flight at a redirect is stale, except a response
        // arriving in the same cycle, which is dropped right away.
        if (redirect_valid) begin
            if (rsp_s) begin
                drop_cnt_nxt_s = out_cnt_r - 2'd1;
            end else begin
                drop_cnt_nxt_s = out_cnt_r;
            end
        end else if (rsp_s && (drop_cnt_r != 2'd0)) begin
            drop_cnt_nxt_s = drop_cnt_r - 2'd1;
        end else begin
            drop_cnt_nxt_s = drop_cnt_r;
        end

        case ({keep_s, pop_s})
            2'b10:   fifo_cnt_nxt_s = fifo_cnt_r + 2'd1;
            2'b01:   fifo_cnt_nxt_s = fifo_cnt_r - 2'd1;
            default: fifo_cnt_nxt_s = fifo_cnt_r;
        endcase
    end

    // Fetch state machine: one BOOT cycle after reset, FLUSH while stale responses remain.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_BOOT;
        end else begin
            case (state_r)
                ST_BOOT: begin
                    state_r <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (redirect_valid && (drop_cnt_nxt_s != 2'd0)) begin
                        state_r <= ST_FLUSH;
                    end else begin
                        state_r <= ST_FETCH;
                    end
                end
                ST_FLUSH: begin
                    if (drop_cnt_nxt_s == 2'd0) begin
                        state_r <= ST_FETCH;
                    end else begin
                        state_r <= ST_FLUSH;
                    end
                end
                default: begin
                    state_r <= ST_BOOT;
                end
            endcase
        end
    end

    // Outstanding and drop counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_cnt_r  <= 2'd0;
            drop_cnt_r <= 2'd0;
        end else begin
            out_cnt_r  <= out_cnt_nxt_s;
            drop_cnt_r <= drop_cnt_nxt_s;
        end
    end

    // Request address and expected-response address; both restart at a redirect target.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_r <= RESET_PC;
            rsp_pc_r   <= RESET_PC;
        end else if (redirect_valid) begin
            fetch_pc_r <= redirect_tgt_s;
            rsp_pc_r   <= redirect_tgt_s;
        end else begin
            if (accept_s) begin
                fetch_pc_r <= fetch_pc_r + 32'd4;
            end else begin
                fetch_pc_r <= fetch_pc_r;
            end
            if (keep_s) begin
                rsp_pc_r <= rsp_pc_r + 32'd4;
            end else begin
                rsp_pc_r <= rsp_pc_r;
            end
        end
    end

    // Two-entry instruction FIFO; a redirect empties it even if a pop coincides.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_r     <= 1'b0;
            wr_ptr_r     <= 1'b0;
            fifo_cnt_r   <= 2'd0;
            fifo_word_r[0] <= 32'd0;
            fifo_word_r[1] <= 32'd0;
            fifo_pc_r[0]   <= 32'd0;
            fifo_pc_r[1]   <= 32'd0;
        end else if (redirect_valid) begin
            rd_ptr_r   <= 1'b0;
            wr_ptr_r   <= 1'b0;
            fifo_cnt_r <= 2'd0;
        end else begin
            fifo_cnt_r <= fifo_cnt_nxt_s;
            if (keep_s) begin
                fifo_word_r[wr_ptr_r] <= imem_rsp_data;
                fifo_pc_r[wr_ptr_r]   <= rsp_pc_r;
                wr_ptr_r              <= wr_ptr_r + 1'b1;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    // Sticky flag for a redirect whose target was not word aligned.
    always_ff @(posedge clk) begin
        if (reset) begin
            misalign_err <= 1'b0;
        end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
            misalign_err <= 1'b1;
        end else begin
            misalign_err <= misalign_err;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Self-checking bench for instr_fetch_unit. A memory model answers accepted
// requests in order with a configurable latency and a data word derived from
// the address. The expected decode stream is simply "consecutive word
// addresses from the last restart point (reset or redirect target)"; the
// stimulus process pushes that stream into a scoreboard queue and a monitor
// pops and compares on every decode handshake.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'd0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [6:0]  instr_op;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        misalign_err;
`endif

    instr_fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc), .instr_op(instr_op)
`ifdef FETCH_MISALIGN_CHECK_EN
        , .misalign_err(misalign_err)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // knobs set by the main sequence, read by the driver
    int unsigned rdy_pct = 100;
    int unsigned lat_min = 1;
    int unsigned lat_max = 1;
    int unsigned ir_pct = 100;
    int unsigned redir_pct = 0;
    logic        force_redir = 1'b0;
    logic [31:0] force_pc = 32'd0;

    typedef struct { logic [31:0] addr; int due; } pend_t;
    typedef struct { logic [31:0] pc; logic [31:0] word; } exp_t;
    pend_t pend_q[$];
    exp_t  exp_q[$];

    logic [31:0] fill_pc = RST_PC;
    logic [31:0] exp_req_addr = RST_PC;
    logic        exp_mis = 1'b0;
    logic [31:0] last_acc = 32'd0;
    logic        saw_wrap = 1'b0;
    int          acc_count = 0;
    int          cyc = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F33;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Driver + memory model + scoreboard producer
    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                exp_q.delete();
                pend_q.delete();
                fill_pc      = RST_PC;
                exp_req_addr = RST_PC;
                exp_mis      = 1'b0;
            end else if (redirect_valid) begin
                exp_q.delete();
                fill_pc      = redirect_pc & 32'hFFFF_FFFC;
                exp_req_addr = fill_pc;
                if (redirect_pc[1:0] != 2'b00) exp_mis = 1'b1;
            end
            while (exp_q.size() < 8) begin
                exp_q.push_back('{pc: fill_pc, word: mem_word(fill_pc)});
                fill_pc = fill_pc + 32'd4;
            end
            #1;
            cyc++;
            imem_req_ready = ($urandom_range(99) < rdy_pct);
            instr_ready    = ($urandom_range(99) < ir_pct);
            if (!reset && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(pend_q[0].addr);
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = $urandom;
            end
            if (force_redir) begin
                redirect_valid = 1'b1;
                redirect_pc    = force_pc;
            end else begin
                redirect_valid = (redir_pct > 0) && !reset && ($urandom_range(99) < redir_pct);
                redirect_pc    = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | {28'd0, 4'($urandom)}) : $urandom;
            end
            @(negedge clk);
            if (reset) begin
                pend_q.delete();
            end else begin
                if (imem_rsp_valid && pend_q.size() > 0) void'(pend_q.pop_front());
                if (redirect_valid) chk("req_during_redirect", {31'd0, imem_req_valid}, 32'd0);
                if (imem_req_valid && imem_req_ready) begin
                    chk("req_addr", imem_req_addr, exp_req_addr);
                    exp_req_addr = exp_req_addr + 32'd4;
                    acc_count++;
                    if (imem_req_addr == 32'd0 && last_acc == 32'hFFFF_FFFC) saw_wrap = 1'b1;
                    last_acc = imem_req_addr;
                    pend_q.push_back('{addr: imem_req_addr, due: cyc + int'($urandom_range(lat_max, lat_min))});
                end
            end
        end
    end

    // Monitor: scoreboard consumer and per-cycle protocol checks
    logic        prev_stall = 1'b0;
    logic        prev_redir = 1'b0;
    logic        prev_reset = 1'b1;
    logic [31:0] prev_instr = 32'd0;
    logic [31:0] prev_pc = 32'd0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
                chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
            end else begin
                if (prev_redir && !prev_reset) chk("valid_after_redirect", {31'd0, instr_valid}, 32'd0);
                if (prev_stall) begin
                    chk("stall_valid", {31'd0, instr_valid}, 32'd1);
                    chk("stall_instr", instr, prev_instr);
                    chk("stall_pc", instr_pc, prev_pc);
                end
                if (instr_valid && instr_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL sb_empty actual_pc=%h expected=none", instr_pc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("instr_pc", instr_pc, e.pc);
                        chk("instr", instr, e.word);
                        chk("instr_op", {25'd0, instr_op}, {25'd0, e.word[6:0]});
                    end
                end
`ifdef FETCH_MISALIGN_CHECK_EN
                chk("misalign_err", {31'd0, misalign_err}, {31'd0, exp_mis});
`endif
            end
            prev_stall = !reset && instr_valid && !instr_ready && !redirect_valid;
            prev_instr = instr;
            prev_pc    = instr_pc;
            prev_redir = redirect_valid;
            prev_reset = reset;
        end
    end

    task automatic do_reset(input int n);
        @(posedge clk); #2 reset = 1'b1;
        repeat (n) @(posedge clk);
        #2 reset = 1'b0;
    endtask

    // Redirect is driven in the cycle after the next clock edge.
    task automatic pulse_redirect(input logic [31:0] pc);
        @(posedge clk); #2 force_pc = pc; force_redir = 1'b1;
        @(posedge clk); #2 force_redir = 1'b0;
    endtask

    task automatic wait_valid_pc(input string name, input logic [31:0] pc);
        bit found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (instr_valid) begin
                found = 1'b1;
                chk(name, instr_pc, pc);
            end
        end
        if (!found) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=no_instr expected_pc=%h", name, pc);
        end
    endtask

    // Main sequence
    initial begin
        int acc0;

        // reset release, streaming at full rate
        do_reset(3);
        @(negedge clk); chk("boot_req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("boot_instr_valid", {31'd0, instr_valid}, 32'd0);
        @(negedge clk); chk("first_req_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("first_req_addr", imem_req_addr, RST_PC);
        @(negedge clk); chk("c2_instr_valid", {31'd0, instr_valid}, 32'd0);
        @(negedge clk); chk("c3_instr_valid", {31'd0, instr_valid}, 32'd1);
        chk("c3_instr_pc", instr_pc, RST_PC);
        repeat (20) @(negedge clk);

        // decode stalled: exactly two requests, FIFO holds 0x0 / 0x4
        ir_pct = 0;
        do_reset(2);
        acc0 = acc_count;
        repeat (8) @(negedge clk);
        chk("stall_req_count", acc_count - acc0, 32'd2);
        chk("stall_head_pc", instr_pc, RST_PC);
        chk("stall_no_req", {31'd0, imem_req_valid}, 32'd0);
        ir_pct = 100;
        @(negedge clk); chk("full_no_req", {31'd0, imem_req_valid}, 32'd0);
        @(negedge clk); chk("after_pop_req", {31'd0, imem_req_valid}, 32'd1);
        chk("after_pop_addr", imem_req_addr, RST_PC + 32'd8);
        repeat (10) @(negedge clk);

        // redirect with two requests outstanding, latency 3
        lat_min = 3; lat_max = 3;
        do_reset(2);
        @(posedge clk);
        pulse_redirect(32'h0000_0100);
        wait_valid_pc("redir_o2_pc", 32'h0000_0100);
        repeat (10) @(negedge clk);

        // redirect coinciding with a response and a pop
        lat_min = 1; lat_max = 1;
        do_reset(2);
        @(posedge clk);
        pulse_redirect(32'h0000_0200);
        @(negedge clk);
        chk("coinc_valid", {31'd0, instr_valid}, 32'd1);
        chk("coinc_rsp", {31'd0, imem_rsp_valid}, 32'd1);
        @(negedge clk);
        chk("coinc_next_valid", {31'd0, instr_valid}, 32'd0);
        chk("coinc_next_req", {31'd0, imem_req_valid}, 32'd1);
        chk("coinc_next_addr", imem_req_addr, 32'h0000_0200);
        repeat (10) @(negedge clk);

        // address wrap
        pulse_redirect(32'hFFFF_FFF8);
        repeat (15) @(negedge clk);
        chk("wrap_seen", {31'd0, saw_wrap}, 32'd1);

`ifdef FETCH_MISALIGN_CHECK_EN
        pulse_redirect(32'h0000_0102);
        wait_valid_pc("misalign_pc", 32'h0000_0100);
        chk("misalign_set", {31'd0, misalign_err}, 32'd1);
        repeat (5) @(negedge clk);
        chk("misalign_sticky", {31'd0, misalign_err}, 32'd1);
`endif

        // randomized traffic with a mid-run reset
        rdy_pct = 70; lat_min = 1; lat_max = 4; ir_pct = 60; redir_pct = 4;
        repeat (1500) @(negedge clk);
        do_reset(2);
        repeat (1500) @(negedge clk);
        redir_pct = 0;
        repeat (30) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
